// File: rtl/demux_pkg.sv
// demux_pkg: shared types and sizes for the demux sequencer.
//   N_CH    - number of demux channels (3-to-8 demux)
//   SEL_W   - select width, clog2(N_CH)
//   DWELL_W - width of the per-channel dwell count
package demux_pkg;
    localparam int N_CH    = 8;
    localparam int SEL_W   = 3;
    localparam int DWELL_W = 4;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} seq_state_t;
    typedef logic [SEL_W-1:0] ch_sel_t;
endpackage

// File: rtl/next_set_bit.sv
// next_set_bit: combinational search for the next channel to strobe.
//   i_mask      - channel mask
//   i_cur       - current channel index
//   i_from_zero - search from bit 0 inclusive (start of a sequence)
//   o_found     - a qualifying set bit exists
//   o_idx       - lowest set bit above i_cur (or lowest overall in from-zero mode)
module next_set_bit
    import demux_pkg::*;
(
    input  logic [N_CH-1:0] i_mask,
    input  ch_sel_t         i_cur,
    input  logic            i_from_zero,
    output logic            o_found,
    output ch_sel_t         o_idx
);
    // Scan high to low so the last hit is the lowest qualifying bit.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_from_zero || i > int'(i_cur))) begin
                o_found = 1'b1;
                o_idx   = ch_sel_t'(i);
            end
        end
    end
endmodule

// File: rtl/demux_sequencer.sv
// demux_sequencer: timed channel-strobe engine driving a 3-to-8 demux.
//   clk, rst          - clock, asynchronous active-high reset
//   mask_valid/ready  - request handshake; mask and dwell latched on transfer
//   mask, dwell       - channels to strobe (ascending) and cycles per channel (0 -> 1)
//   abort             - cancels a running sequence (DRIVE/GAP only)
//   demux_in/sel      - demux drive; sel only changes while demux_in is low
//   busy, done        - sequence active; one-cycle end-of-sequence pulse
module demux_sequencer
    import demux_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               mask_valid,
    output logic               mask_ready,
    input  logic [N_CH-1:0]    mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               abort,
    output logic               demux_in,
    output logic [SEL_W-1:0]   demux_sel,
    output logic               busy,
    output logic               done
);
    seq_state_t         r_state, w_state_nxt;
    logic [N_CH-1:0]    r_mask;
    logic [DWELL_W-1:0] r_dwell, r_count, w_dwell_eff;
    ch_sel_t            r_sel;
    logic               r_in, r_busy, r_done, r_ready;
    logic               w_in_nxt, w_busy_nxt, w_done_nxt, w_ready_nxt;
    logic               w_xfer, w_last, w_found;
    ch_sel_t            w_idx;

    assign w_xfer      = mask_valid && r_ready;
    assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign w_last      = (r_count <= DWELL_W'(1));

    // In IDLE the search runs on the incoming mask from bit 0; afterwards
    // it runs on the latched mask from the current channel.
    next_set_bit u_nsb (
        .i_mask      ((r_state == IDLE) ? mask : r_mask),
        .i_cur       (r_sel),
        .i_from_zero (r_state == IDLE),
        .o_found     (w_found),
        .o_idx       (w_idx)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; abort outranks both the count and the channel step.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_xfer) w_state_nxt = (mask != '0) ? DRIVE : DONE;
            DRIVE: begin
                if (abort)       w_state_nxt = DONE;
                else if (w_last) w_state_nxt = w_found ? GAP : DONE;
            end
            GAP:   w_state_nxt = abort ? DONE : DRIVE;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        w_in_nxt    = (w_state_nxt == DRIVE);
        w_busy_nxt  = (w_state_nxt == DRIVE) || (w_state_nxt == GAP);
        w_done_nxt  = (w_state_nxt == DONE);
        w_ready_nxt = (w_state_nxt == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_in    <= w_in_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Datapath: latched request, dwell counter and channel select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask  <= '0;
            r_dwell <= '0;
            r_count <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_xfer) begin
                    r_mask  <= mask;
                    r_dwell <= w_dwell_eff;
                    r_count <= w_dwell_eff;
                    if (w_found) r_sel <= w_idx;
                end
                DRIVE: begin
                    r_count <= r_count - DWELL_W'(1);
                    // sel moves to the next channel as the gap begins
                    if (w_state_nxt == GAP) r_sel <= w_idx;
                end
                GAP: r_count <= r_dwell;
                default: ;
            endcase
        end
    end

    assign mask_ready = r_ready;
    assign demux_in   = r_in;
    assign demux_sel  = r_sel;
    assign busy       = r_busy;
    assign done       = r_done;
endmodule

// File: tb/tb_demux_sequencer.sv
module tb_demux_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       mask_valid;
    logic       mask_ready;
    logic [7:0] mask;
    logic [3:0] dwell;
    logic       abort;
    logic       demux_in;
    logic [2:0] demux_sel;
    logic       busy;
    logic       done;

    demux_sequencer dut (
        .clk(clk), .rst(rst), .mask_valid(mask_valid), .mask_ready(mask_ready),
        .mask(mask), .dwell(dwell), .abort(abort), .demux_in(demux_in),
        .demux_sel(demux_sel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       in;
        bit [2:0] sel;
        bit       busy;
        bit       done;
        bit       ready;
    } exp_t;

    exp_t     tr[$];
    bit [2:0] model_sel;
    int       total = 0;
    int       bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(bit i, bit [2:0] s, bit b, bit d, bit r);
        exp_t e;
        e.in = i; e.sel = s; e.busy = b; e.done = d; e.ready = r;
        return e;
    endfunction

    // Expected per-cycle trace starting at cycle 1 after the accept edge.
    task automatic build(input bit [7:0] m, input bit [3:0] d, input int ab);
        int       dd;
        bit       first;
        bit [2:0] msel;
        tr.delete();
        dd    = (d == 0) ? 1 : int'(d);
        first = 1'b1;
        msel  = model_sel;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (!first) tr.push_back(mk(1'b0, 3'(i), 1'b1, 1'b0, 1'b0));
                for (int j = 0; j < dd; j++) tr.push_back(mk(1'b1, 3'(i), 1'b1, 1'b0, 1'b0));
                first = 1'b0;
                msel  = 3'(i);
            end
        end
        if (ab >= 1 && ab <= tr.size()) begin
            msel = tr[ab-1].sel;
            while (tr.size() > ab) void'(tr.pop_back());
        end
        tr.push_back(mk(1'b0, msel, 1'b0, 1'b1, 1'b0));
        tr.push_back(mk(1'b0, msel, 1'b0, 1'b0, 1'b1));
        model_sel = msel;
    endtask

    task automatic chk_cycle(input string tag, input int c, input exp_t e);
        chk($sformatf("%s c%0d in", tag, c),    demux_in,   e.in);
        chk($sformatf("%s c%0d sel", tag, c),   demux_sel,  e.sel);
        chk($sformatf("%s c%0d busy", tag, c),  busy,       e.busy);
        chk($sformatf("%s c%0d done", tag, c),  done,       e.done);
        chk($sformatf("%s c%0d ready", tag, c), mask_ready, e.ready);
    endtask

    // ab: cycle in which abort is held high (0 = none). noise: keep
    // mask_valid toggling with random payloads while the sequence runs.
    task automatic run_txn(input string tag, input bit [7:0] m, input bit [3:0] d,
                           input int ab, input bit noise);
        build(m, d, ab);
        @(negedge clk);
        mask_valid = 1'b1;
        mask       = m;
        dwell      = d;
        abort      = 1'($urandom_range(0, 1));  // ignored in IDLE
        for (int c = 1; c <= tr.size(); c++) begin
            @(posedge clk);
            #1;
            chk_cycle(tag, c, tr[c-1]);
            if (c < tr.size()) begin
                @(negedge clk);
                abort      = (c == ab);
                mask_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                mask       = 8'($urandom);
                dwell      = 4'($urandom);
            end
        end
        mask_valid = 1'b0;
        abort      = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        mask_valid = 1'b0;
        mask       = '0;
        dwell      = '0;
        abort      = 1'b0;
        model_sel  = '0;
        #2;
        chk_cycle("reset", 0, mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        rst = 1'b0;

        run_txn("m85d2", 8'b1000_0101, 4'd2, 0, 1'b0);
        run_txn("mFFd0", 8'hFF, 4'd0, 0, 1'b0);
        run_txn("m00d5", 8'h00, 4'd5, 0, 1'b0);
        run_txn("m12abort", 8'h12, 4'd4, 2, 1'b0);
        run_txn("gapabort", 8'h0A, 4'd1, 2, 1'b0);
        run_txn("noise", 8'hA5, 4'd3, 0, 1'b1);

        // Asynchronous reset in the middle of a long dwell on channel 7.
        @(negedge clk);
        mask_valid = 1'b1; mask = 8'h80; dwell = 4'd15;
        @(posedge clk);
        #1;
        mask_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk_cycle("rstmid", c, mk(1'b1, 3'd7, 1'b1, 1'b0, 1'b0));
            @(posedge clk);
            #1;
        end
        #3;
        rst = 1'b1;
        #1;
        chk_cycle("rstasync", 7, mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        rst = 1'b0;
        model_sel = '0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk_cycle("postrst", c, mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
        end

        for (int t = 0; t < 25; t++) begin
            bit [7:0] rm;
            bit [3:0] rd;
            int       ra;
            rm = 8'($urandom);
            if (t % 7 == 0) rm = 8'(1 << $urandom_range(0, 7));
            rd = 4'($urandom_range(0, 4));
            ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0;
            run_txn($sformatf("rnd%0d", t), rm, rd, ra, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
